// File: rtl/mfa_pkg.sv
// Shared definitions for the nucleotide sequence path: symbol codes,
// symbols-per-word derivation and the packer state encoding.
package mfa_pkg;

  localparam logic [1:0] SYM_A = 2'b00;
  localparam logic [1:0] SYM_C = 2'b01;
  localparam logic [1:0] SYM_G = 2'b10;
  localparam logic [1:0] SYM_T = 2'b11;

  function automatic int unsigned spw(input int unsigned data_len);
    return data_len / 2;
  endfunction

  typedef enum logic [1:0] {
    S_FILL,
    S_WRITE,
    S_DONE,
    S_FULL
  } packer_state_e;

endpackage

// File: rtl/symbol_packer.sv
// Packs a valid/ready stream of 2-bit symbols LSB-first into DATA_LEN-bit
// words and writes them to consecutive sequence-memory addresses.
module symbol_packer
  import mfa_pkg::*;
#(
  parameter int unsigned ADDR_LEN = 6,
  parameter int unsigned DATA_LEN = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                clear,
  input  logic                sym_valid,
  input  logic [1:0]          symbol,
  output logic                sym_ready,
  input  logic                flush,
  output logic                wr_en,
  output logic [ADDR_LEN-1:0] wr_addr,
  output logic [DATA_LEN-1:0] wr_data,
  input  logic                wr_ready,
  output logic [ADDR_LEN+3:0] sym_count,
  output logic                done,
  output logic                overflow
);

  localparam int unsigned       SPW       = spw(DATA_LEN);
  localparam int unsigned       SLOT_W    = $clog2(SPW);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SPW - 1);
  localparam logic [ADDR_LEN-1:0] LAST_ADDR = '1;

  packer_state_e       r_state;
  logic [SLOT_W-1:0]   r_slot;
  logic [DATA_LEN-1:0] r_word;
  logic                r_flush_pend;
  logic [DATA_LEN-1:0] w_word_next;
  logic                w_accept;

  assign w_accept = (r_state == S_FILL) && sym_valid && sym_ready;

  always_comb begin
    w_word_next = r_word;
    w_word_next[{r_slot, 1'b0} +: 2] = symbol;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= S_FILL;
      r_slot       <= '0;
      r_word       <= '0;
      r_flush_pend <= 1'b0;
      sym_ready    <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      sym_count    <= '0;
      done         <= 1'b0;
      overflow     <= 1'b0;
    end else if (clear) begin
      r_state      <= S_FILL;
      r_slot       <= '0;
      r_word       <= '0;
      r_flush_pend <= 1'b0;
      sym_ready    <= 1'b1;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      sym_count    <= '0;
      done         <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            r_word    <= w_word_next;
            r_slot    <= r_slot + 1'b1;
            sym_count <= sym_count + 1'b1;
          end
          // An accept is packed before a same-cycle flush, so a word-completing
          // symbol plus flush yields a single write followed by DONE.
          if (w_accept && (r_slot == LAST_SLOT || flush)) begin
            r_state      <= S_WRITE;
            wr_en        <= 1'b1;
            wr_data      <= w_word_next;
            sym_ready    <= 1'b0;
            r_flush_pend <= flush;
          end else if (flush && !w_accept) begin
            sym_ready <= 1'b0;
            if (r_slot == '0) begin
              r_state <= S_DONE;
              done    <= 1'b1;
            end else begin
              r_state      <= S_WRITE;
              wr_en        <= 1'b1;
              wr_data      <= r_word;
              r_flush_pend <= 1'b1;
            end
          end else begin
            sym_ready <= 1'b1;
          end
        end

        S_WRITE: begin
          if (wr_ready) begin
            wr_en        <= 1'b0;
            r_word       <= '0;
            r_slot       <= '0;
            r_flush_pend <= 1'b0;
            if (wr_addr == LAST_ADDR) begin
              r_state  <= S_FULL;
              overflow <= 1'b1;
              done     <= 1'b1;
            end else begin
              wr_addr <= wr_addr + 1'b1;
              if (r_flush_pend || flush) begin
                r_state <= S_DONE;
                done    <= 1'b1;
              end else begin
                r_state   <= S_FILL;
                sym_ready <= 1'b1;
              end
            end
          end else if (flush) begin
            r_flush_pend <= 1'b1;
          end
        end

        S_DONE, S_FULL: begin
          sym_ready <= 1'b0;
        end

        default: begin
          r_state <= S_FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_symbol_packer.sv
// Randomized scoreboard bench for symbol_packer against a sum-of-powers
// packing model.
module tb_symbol_packer;

  localparam int unsigned AL    = 6;
  localparam int unsigned DL    = 8;
  localparam int unsigned SPW   = DL / 2;
  localparam int unsigned WORDS = 1 << AL;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          clear = 1'b0;
  logic          sym_valid = 1'b0;
  logic [1:0]    symbol = 2'b00;
  logic          flush = 1'b0;
  logic          wr_ready = 1'b1;
  logic          sym_ready;
  logic          wr_en;
  logic [AL-1:0] wr_addr;
  logic [DL-1:0] wr_data;
  logic [AL+3:0] sym_count;
  logic          done;
  logic          overflow;

  symbol_packer #(.ADDR_LEN(AL), .DATA_LEN(DL)) dut (
    .CLK(CLK), .RST(RST), .clear(clear), .sym_valid(sym_valid),
    .symbol(symbol), .sym_ready(sym_ready), .flush(flush), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .sym_count(sym_count), .done(done), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int unsigned addr;
    int unsigned data;
  } wr_t;

  wr_t         exp_q[$];
  int unsigned cur[$];
  int unsigned m_count = 0;
  int unsigned m_addr = 0;
  bit          m_done = 0;
  bit          m_full = 0;

  int checks = 0;
  int errors = 0;
  bit rnd_ready = 0;
  int stall_left = 0;
  int wr_cycles = 0;
  int last_wr_cycles = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout expected=event at %0t", name, $time);
  endtask

  task automatic model_reset();
    cur.delete();
    m_count = 0;
    m_addr  = 0;
    m_done  = 0;
    m_full  = 0;
  endtask

  // Word value = sum of symbol_i * 4^i over the symbols collected so far.
  task automatic model_emit(output bit emitted);
    wr_t w;
    int unsigned val;
    emitted = 0;
    if (!m_full && cur.size() > 0) begin
      val = 0;
      foreach (cur[i]) val += cur[i] * (4 ** i);
      w.addr = m_addr;
      w.data = val;
      exp_q.push_back(w);
      m_addr++;
      if (m_addr == WORDS) m_full = 1;
      emitted = 1;
    end
    cur.delete();
  endtask

  initial forever begin
    @(negedge CLK);
    if (wr_en && stall_left > 0) begin
      wr_ready = 1'b0;
      stall_left--;
    end else begin
      wr_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial forever begin
    @(negedge CLK);
    #2;
    if (RST && !clear && wr_en) begin
      wr_cycles++;
      chk("sym_ready_in_write", sym_ready, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%0h@%0h expected=none", wr_data, wr_addr);
      end else begin
        chk("wr_addr", wr_addr, exp_q[0].addr);
        chk("wr_data", wr_data, exp_q[0].data);
        if (wr_ready) begin
          void'(exp_q.pop_front());
          last_wr_cycles = wr_cycles;
          wr_cycles = 0;
        end
      end
    end
  end

  task automatic drive_sym(input logic [1:0] s, input bit fl);
    int t;
    bit emitted;
    t = 0;
    emitted = 0;
    symbol = s;
    sym_valid = 1'b1;
    #1;
    while (!sym_ready) begin
      if (t > 300) begin
        fail_now("sym_ready_wait");
        sym_valid = 1'b0;
        return;
      end
      t++;
      @(negedge CLK);
      #1;
    end
    flush = fl;
    m_count++;
    cur.push_back(int'(s));
    if (cur.size() == SPW || fl) model_emit(emitted);
    if (fl) m_done = 1;
    @(negedge CLK);
    sym_valid = 1'b0;
    flush = 1'b0;
    if (emitted) begin
      #1;
      chk("write_latency", wr_en, 1);
    end
  endtask

  task automatic flush_only();
    int t;
    bit had;
    bit emitted;
    t = 0;
    #1;
    while (!sym_ready) begin
      if (t > 300) begin
        fail_now("flush_ready_wait");
        return;
      end
      t++;
      @(negedge CLK);
      #1;
    end
    flush = 1'b1;
    had = (cur.size() > 0);
    model_emit(emitted);
    m_done = 1;
    @(negedge CLK);
    flush = 1'b0;
    #1;
    if (!had) chk("done_latency", done, 1);
    else      chk("flush_write_latency", wr_en, 1);
  endtask

  task automatic check_end();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 600) begin
      @(negedge CLK);
      t++;
    end
    if (exp_q.size() > 0) fail_now("write_drain");
    repeat (2) @(negedge CLK);
    #3;
    chk("done", done, (m_done || m_full) ? 1 : 0);
    chk("overflow", overflow, m_full ? 1 : 0);
    chk("sym_count", sym_count, m_count);
    chk("wr_en_idle", wr_en, 0);
    chk("sym_ready_state", sym_ready, (m_done || m_full) ? 0 : 1);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b0;
    #1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_sym_count", sym_count, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_sym_ready", sym_ready, 0);
    exp_q.delete();
    model_reset();
    stall_left = 0;
    wr_cycles = 0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("sym_ready_at_release", sym_ready, 0);
    @(negedge CLK);
    #1;
    chk("sym_ready_after_release", sym_ready, 1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge CLK);
    exp_q.delete();
    model_reset();
    stall_left = 0;
    wr_cycles = 0;
    @(negedge CLK);
    clear = 1'b0;
    #1;
    chk("clr_wr_en", wr_en, 0);
    chk("clr_wr_addr", wr_addr, 0);
    chk("clr_sym_count", sym_count, 0);
    chk("clr_done", done, 0);
    chk("clr_overflow", overflow, 0);
    chk("clr_sym_ready", sym_ready, 1);
    @(negedge CLK);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit fl_last;
    @(negedge CLK);
    do_reset();

    // Full word 0,1,2,3 -> E4 at address 0
    for (int i = 0; i < 4; i++) drive_sym(2'(i), 0);
    check_end();

    // Partial word 3,3 then flush -> 0F
    do_clear();
    drive_sym(2'd3, 0);
    drive_sym(2'd3, 0);
    flush_only();
    check_end();

    // Three-cycle memory stall holds the write
    do_clear();
    stall_left = 3;
    for (int i = 0; i < 4; i++) drive_sym(2'(i), 0);
    check_end();
    chk("stall_write_cycles", last_wr_cycles, 4);

    // Flush on an empty slot after a full word
    do_clear();
    for (int i = 0; i < 4; i++) drive_sym(2'(3 - i), 0);
    flush_only();
    check_end();

    // Flush straight after restart
    do_clear();
    flush_only();
    check_end();

    // Word-completing symbol with flush in the same cycle
    do_clear();
    drive_sym(2'd1, 0);
    drive_sym(2'd2, 0);
    drive_sym(2'd0, 0);
    drive_sym(2'd3, 1);
    check_end();

    // Reset while a write is stalled, then a fresh word
    do_clear();
    stall_left = 5;
    drive_sym(2'd1, 0);
    drive_sym(2'd2, 0);
    drive_sym(2'd3, 0);
    drive_sym(2'd0, 0);
    @(negedge CLK);
    do_reset();
    for (int i = 0; i < 4; i++) drive_sym(2'd2, 0);
    check_end();

    // Fill the whole memory
    do_clear();
    rnd_ready = 1;
    for (int i = 0; i < SPW * WORDS; i++) drive_sym(2'($urandom_range(0, 3)), 0);
    check_end();

    // Random sequences with random gaps and flush placement
    for (int tr = 0; tr < 12; tr++) begin
      do_clear();
      n = $urandom_range(0, 25);
      fl_last = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        drive_sym(2'($urandom_range(0, 3)), (i == n - 1) && fl_last);
        repeat ($urandom_range(0, 2)) @(negedge CLK);
      end
      if (!(n > 0 && fl_last)) flush_only();
      check_end();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
